// File: rtl/program_loader.sv
// Streams bytes into the shared 32-byte memory bus, then releases the CPU core and waits for halt.
// Define LOADER_CKSUM_EN to require a trailing checksum byte before the core is released.
module program_loader #(
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              halt,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data,
    output logic              mem_data_e,
    output logic              mem_wr,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrite,
`ifdef LOADER_CKSUM_EN
        StCksum,
`endif
        StRun,
        StHalted,
        StFault
    } state_e;

    localparam logic [AWIDTH-1:0] LastAddr = AWIDTH'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] ptr_q, ptr_d;
    logic              last_q, last_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] mem_data_q, mem_data_d;
    logic              mem_data_e_q, mem_data_e_d;
    logic              mem_wr_q, mem_wr_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              accept;
`ifdef LOADER_CKSUM_EN
    logic [DWIDTH-1:0] sum_q, sum_d;
    logic [DWIDTH-1:0] cksum_total;
`endif

`ifdef LOADER_CKSUM_EN
    assign in_ready = (state_q == StLoad) || (state_q == StCksum);
`else
    assign in_ready = (state_q == StLoad);
`endif
    assign accept = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        last_d     = last_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
`ifdef LOADER_CKSUM_EN
        sum_d       = sum_q;
        cksum_total = sum_q + in_data;
`endif
        case (state_q)
            StIdle, StHalted, StFault: begin
                if (start) begin
                    state_d = StLoad;
                    ptr_d   = '0;
`ifdef LOADER_CKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            StLoad: begin
                if (accept) begin
                    mem_data_d = in_data;
                    mem_addr_d = ptr_q;
                    last_d     = in_last;
`ifdef LOADER_CKSUM_EN
                    sum_d      = cksum_total;
`endif
                    state_d    = StWrite;
                end
            end
            StWrite: begin
                if (last_q) begin
`ifdef LOADER_CKSUM_EN
                    state_d = StCksum;
`else
                    state_d = StRun;
`endif
                end else if (ptr_q == LastAddr) begin
                    // Memory is full but the stream has not ended: never wrap.
                    state_d = StFault;
                end else begin
                    ptr_d   = ptr_q + AWIDTH'(1);
                    state_d = StLoad;
                end
            end
`ifdef LOADER_CKSUM_EN
            StCksum: begin
                if (accept) begin
                    state_d = (cksum_total == '0) ? StRun : StFault;
                end
            end
`endif
            StRun: begin
                if (halt) begin
                    state_d = StHalted;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, decoded from the state being entered.
        mem_wr_d     = (state_d == StWrite);
        mem_data_e_d = (state_d == StWrite);
        cpu_rst_d    = (state_d == StRun) || (state_d == StHalted);
        done_d       = (state_d == StHalted);
        error_d      = (state_d == StFault);
`ifdef LOADER_CKSUM_EN
        busy_d = (state_d == StLoad) || (state_d == StWrite) || (state_d == StCksum);
`else
        busy_d = (state_d == StLoad) || (state_d == StWrite);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            last_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_data_e_q <= 1'b0;
            mem_wr_q     <= 1'b0;
            cpu_rst_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef LOADER_CKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            last_q       <= last_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_data_e_q <= mem_data_e_d;
            mem_wr_q     <= mem_wr_d;
            cpu_rst_q    <= cpu_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef LOADER_CKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_data_e = mem_data_e_q;
    assign mem_wr     = mem_wr_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: per-cycle vector table plus overflow, reset and checksum sequences.
// Honours LOADER_CKSUM_EN so the same bench covers both builds.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       halt = 1'b0;
    logic       in_ready;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_data_e;
    logic       mem_wr;
    logic       cpu_rst;
    logic       busy;
    logic       done;
    logic       error;

    int total = 0;
    int bad   = 0;

    program_loader #(
        .AWIDTH(5),
        .DWIDTH(8),
        .DEPTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .halt      (halt),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_data_e(mem_data_e),
        .mem_wr    (mem_wr),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, v, l, h;
        logic [7:0] d;
        logic       rdy, wr;
        logic [4:0] addr;
        logic [7:0] data;
        logic       crst, bsy, dn, err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic v, input logic [7:0] d,
                                input logic l, input logic h, input logic rdy, input logic wr,
                                input logic [4:0] addr, input logic [7:0] data,
                                input logic crst, input logic bsy, input logic dn,
                                input logic err);
        vec_t r;
        r.st = st; r.v = v; r.d = d; r.l = l; r.h = h;
        r.rdy = rdy; r.wr = wr; r.addr = addr; r.data = data;
        r.crst = crst; r.bsy = bsy; r.dn = dn; r.err = err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic rdy, input logic wr,
                            input logic [4:0] addr, input logic [7:0] data, input logic crst,
                            input logic bsy, input logic dn, input logic err);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".mem_wr"}, 32'(mem_wr), 32'(wr));
        chk({tag, ".mem_data_e"}, 32'(mem_data_e), 32'(wr));
        if (wr) begin
            chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
            chk({tag, ".mem_data"}, 32'(mem_data), 32'(data));
        end
        chk({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(crst));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".error"}, 32'(error), 32'(err));
    endtask

    task automatic pulse_halt();
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
    endtask

`ifdef LOADER_CKSUM_EN
    // Two program bytes 0x10,0x20 followed by checksum ck; entered from HALTED or FAULT.
    task automatic cks_run(input logic [7:0] ck, input logic ok, input string tag);
        int writes = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h10; in_last = 1'b0;
        @(negedge clk);
        if (mem_wr) writes++;
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h20; in_last = 1'b1;
        @(negedge clk);
        if (mem_wr) writes++;
        in_data = ck;
        @(negedge clk);
        chk({tag, ".cksum_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".cksum_no_wr"}, 32'(mem_wr), 32'd0);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk({tag, ".writes"}, writes, 2);
        chk({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(ok));
        chk({tag, ".error"}, 32'(error), 32'(!ok));
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask
`endif

    initial begin
        int k;
        int w;
        logic rdy;

        // Rows: inputs (st,v,d,l,h) then expected outputs during that cycle.
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA1, 0, 1, 1, 0, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h22, 0, 0, 0, 1, 0, 8'hA1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h22, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h43, 1, 0, 0, 1, 1, 8'h22, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h43, 1, 0, 1, 0, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 2, 8'h43, 0, 1, 0, 0));
`ifdef LOADER_CKSUM_EN
        // A1+22+43 = 0x106 -> checksum 0xFA.
        vecs.push_back(mk(0, 1, 8'hFA, 1, 0, 1, 0, 0, 8'h00, 0, 1, 0, 0));
`endif
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h55, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h55, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h66, 1, 0, 1, 0, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 1, 8'h66, 0, 1, 0, 0));
`ifdef LOADER_CKSUM_EN
        // 55+66 = 0xBB -> checksum 0x45.
        vecs.push_back(mk(0, 1, 8'h45, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 0));
`endif
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0));

        repeat (2) @(negedge clk);
        rst = 1'b1;
        foreach (vecs[i]) begin
            @(negedge clk);
            chk_outs($sformatf("row%0d", i), vecs[i].rdy, vecs[i].wr, vecs[i].addr,
                     vecs[i].data, vecs[i].crst, vecs[i].bsy, vecs[i].dn, vecs[i].err);
            start = vecs[i].st; in_valid = vecs[i].v; in_data = vecs[i].d;
            in_last = vecs[i].l; halt = vecs[i].h;
        end

        // Overflow: 33 bytes without in_last from HALTED.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        w = 0;
        for (int c = 0; c < 90; c++) begin
            in_valid = 1'b1; in_last = 1'b0; in_data = 8'(k);
            rdy = in_ready;
            @(negedge clk);
            if (rdy) k++;
            if (mem_wr) begin
                chk($sformatf("ovf.addr%0d", w), 32'(mem_addr), w);
                chk($sformatf("ovf.data%0d", w), 32'(mem_data), w);
                w++;
            end
        end
        in_valid = 1'b0;
        chk("ovf.writes", w, 32);
        chk("ovf.error", 32'(error), 32'd1);
        chk("ovf.cpu_rst", 32'(cpu_rst), 32'd0);
        chk("ovf.busy", 32'(busy), 32'd0);
        chk("ovf.in_ready", 32'(in_ready), 32'd0);

        // Restart after fault: error clears, load starts at address 0.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rld.error", 32'(error), 32'd0);
        chk("rld.in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
        @(negedge clk);
        chk_outs("rld.wr", 0, 1, 0, 8'h77, 0, 1, 0, 0);
`ifdef LOADER_CKSUM_EN
        in_data = 8'h89; in_last = 1'b0;
        @(negedge clk);
`else
        in_valid = 1'b0;
`endif
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("rld.cpu_rst", 32'(cpu_rst), 32'd1);
        pulse_halt();

        // Reset asserted while byte 3 is being written.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h30 + i);
            @(negedge clk);
            in_valid = 1'b0;
            if (i < 3) @(negedge clk);
        end
        chk("rstw.pre_wr", 32'(mem_wr), 32'd1);
        chk("rstw.pre_addr", 32'(mem_addr), 32'd3);
        rst = 1'b0;
        #1;
        chk_outs("rstw", 0, 0, 0, 8'h00, 0, 0, 0, 0);
        chk("rstw.mem_addr", 32'(mem_addr), 32'd0);
        chk("rstw.mem_data", 32'(mem_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_outs("rstw.idle", 0, 0, 0, 8'h00, 0, 0, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1;
        @(negedge clk);
        chk_outs("rstw.reload", 0, 1, 0, 8'h5A, 0, 1, 0, 0);
`ifdef LOADER_CKSUM_EN
        in_data = 8'hA6;
        @(negedge clk);
`else
        in_valid = 1'b0;
`endif
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("rstw.cpu_rst", 32'(cpu_rst), 32'd1);
        pulse_halt();
        chk("rstw.done", 32'(done), 32'd1);

`ifdef LOADER_CKSUM_EN
        cks_run(8'hD0, 1'b1, "cks_ok");
        pulse_halt();
        cks_run(8'hD1, 1'b0, "cks_bad");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
